// File: rtl/cpu24_pkg.sv
// Shared definitions for the 65C2424 front end: prefix byte codes, the
// address/register width encodings, and the byte class enum used by the
// prefix classifier and the prefix sequencer.
package cpu24_pkg;

  // Legal width-prefix bytes
  localparam logic [7:0] PFX_A24 = 8'h1F;
  localparam logic [7:0] PFX_R16 = 8'h4F;
  localparam logic [7:0] PFX_R24 = 8'h8F;
  localparam logic [7:0] PFX_A_R = 8'h5F;
  localparam logic [7:0] PFX_B24 = 8'h9F;

  // Reserved prefix slots that must be flagged
  localparam logic [7:0] ILL_2F = 8'h2F;
  localparam logic [7:0] ILL_3F = 8'h3F;
  localparam logic [7:0] ILL_CF = 8'hCF;
  localparam logic [7:0] ILL_DF = 8'hDF;
  localparam logic [7:0] ILL_FF = 8'hFF;

  // Width encodings
  localparam logic       AW_16 = 1'b0;
  localparam logic       AW_24 = 1'b1;
  localparam logic [1:0] RW_8  = 2'b00;
  localparam logic [1:0] RW_16 = 2'b01;
  localparam logic [1:0] RW_24 = 2'b10;

  typedef enum logic [1:0] {
    OPCODE  = 2'd0,
    PREFIX  = 2'd1,
    ILLEGAL = 2'd2
  } pfx_class_t;

endpackage

// File: rtl/prefix_classify.sv
// Combinational byte classifier. Maps a fetched byte to opcode, legal
// prefix or illegal prefix, and for legal prefixes gives the widths the
// prefix selects. Also used by the disassembler trace path.
//   byte_in : fetched byte
//   cls     : byte class
//   aw      : address width selected by a legal prefix (AW_16 otherwise)
//   rw      : register width selected by a legal prefix (RW_8 otherwise)
import cpu24_pkg::*;

module prefix_classify (
  input  logic [7:0] byte_in,
  output pfx_class_t cls,
  output logic       aw,
  output logic [1:0] rw
);

  always_comb begin
    cls = OPCODE;
    aw  = AW_16;
    rw  = RW_8;
    case (byte_in)
      PFX_A24: begin cls = PREFIX; aw = AW_24; rw = RW_8;  end
      PFX_R16: begin cls = PREFIX; aw = AW_16; rw = RW_16; end
      PFX_R24: begin cls = PREFIX; aw = AW_16; rw = RW_24; end
      PFX_A_R: begin cls = PREFIX; aw = AW_24; rw = RW_16; end
      PFX_B24: begin cls = PREFIX; aw = AW_24; rw = RW_24; end
      ILL_2F, ILL_3F, ILL_CF, ILL_DF, ILL_FF: cls = ILLEGAL;
      default: cls = OPCODE;
    endcase
  end

endmodule

// File: rtl/prefix_sequencer.sv
// Absorbs width-prefix bytes ahead of each opcode and presents the decoder
// with one tagged opcode per transfer through a one-entry output register.
//   clk, reset_n          : core clock, async active-low reset
//   flush                 : redirect; drops pending prefix and output entry
//   in_valid/in_byte      : fetch stream, accepted when in_valid && in_ready
//   in_ready              : sequencer can take a byte this cycle
//   out_valid/out_ready   : descriptor handshake to the decoder
//   out_op/out_aw/out_rw  : opcode and effective address/register widths
//   out_plen              : prefix bytes consumed ahead of the opcode
//   pfx_err               : one-cycle pulse for an illegal or stacked prefix
//
// state | meaning
// NOPFX | no prefix pending, widths are 16-bit address / 8-bit register
// PFX   | a legal prefix is pending in pend_aw / pend_rw
import cpu24_pkg::*;

module prefix_sequencer #(
  parameter int LEN_W = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  input  logic [7:0]       in_byte,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_op,
  output logic             out_aw,
  output logic [1:0]       out_rw,
  output logic [LEN_W-1:0] out_plen,
  output logic             pfx_err
);

  typedef enum logic {
    NOPFX = 1'b0,
    PFX   = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic             pend_aw_q, pend_aw_d;
  logic [1:0]       pend_rw_q, pend_rw_d;
  logic [LEN_W-1:0] plen_q, plen_d;
  logic             err_d;
  logic             load_op;

  pfx_class_t       cls;
  logic             cls_aw;
  logic [1:0]       cls_rw;
  logic             accept;
  logic             cur_aw;
  logic [1:0]       cur_rw;
  logic [LEN_W-1:0] plen_inc;

  prefix_classify u_classify (
    .byte_in (in_byte),
    .cls     (cls),
    .aw      (cls_aw),
    .rw      (cls_rw)
  );

  // A prefix byte obeys the same backpressure as an opcode so the stream
  // order seen by the decoder never changes.
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  assign cur_aw   = (state_q == PFX) ? pend_aw_q : AW_16;
  assign cur_rw   = (state_q == PFX) ? pend_rw_q : RW_8;
  assign plen_inc = (plen_q == {LEN_W{1'b1}}) ? plen_q : plen_q + LEN_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= NOPFX;
      pend_aw_q <= AW_16;
      pend_rw_q <= RW_8;
      plen_q    <= '0;
      pfx_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pend_aw_q <= pend_aw_d;
      pend_rw_q <= pend_rw_d;
      plen_q    <= plen_d;
      pfx_err   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pend_aw_d = pend_aw_q;
    pend_rw_d = pend_rw_q;
    plen_d    = plen_q;
    err_d     = 1'b0;
    load_op   = 1'b0;
    if (flush) begin
      state_d   = NOPFX;
      pend_aw_d = AW_16;
      pend_rw_d = RW_8;
      plen_d    = '0;
    end else if (accept) begin
      case (cls)
        PREFIX: begin
          // Stacking is flagged but the newest prefix still takes effect.
          err_d     = (state_q == PFX);
          state_d   = PFX;
          pend_aw_d = cls_aw;
          pend_rw_d = cls_rw;
          plen_d    = plen_inc;
        end
        ILLEGAL: begin
          err_d  = 1'b1;
          plen_d = plen_inc;
        end
        default: begin
          load_op   = 1'b1;
          state_d   = NOPFX;
          pend_aw_d = AW_16;
          pend_rw_d = RW_8;
          plen_d    = '0;
        end
      endcase
    end
  end

  // Output register: load wins over pop so a transfer and a new opcode can
  // share a cycle; a flush empties it even if it was handshaken that cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_op    <= 8'h00;
      out_aw    <= AW_16;
      out_rw    <= RW_8;
      out_plen  <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_op) begin
      out_valid <= 1'b1;
      out_op    <= in_byte;
      out_aw    <= cur_aw;
      out_rw    <= cur_rw;
      out_plen  <= plen_q;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
